// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles every signal of the memory-access stage except clk/reset.
//   ex_*        : instruction presented by the execute stage (held while stall=1)
//   stall       : upstream hold request
//   d_*         : data-memory request/acknowledge bus
//   wb_valid, d_data_read, res, PC, opcode, rd, misaligned : MEM/WB register
// master: the memory stage itself; slave: its environment (EX, memory, WB).
interface mem_stage_if;
  logic        ex_valid;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_res;
  logic [31:0] ex_rs2;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;

  logic        stall;

  logic        d_req;
  logic [31:0] d_address;
  logic [3:0]  d_we;
  logic [31:0] d_data_write;
  logic        d_ack;
  logic [31:0] d_data_in;

  logic        wb_valid;
  logic [31:0] d_data_read;
  logic [31:0] res;
  logic [31:0] PC;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        misaligned;

  modport master (
    input  ex_valid, ex_opcode, ex_funct3, ex_res, ex_rs2, ex_pc, ex_rd,
    input  d_ack, d_data_in,
    output stall, d_req, d_address, d_we, d_data_write,
    output wb_valid, d_data_read, res, PC, opcode, rd, misaligned
  );

  modport slave (
    output ex_valid, ex_opcode, ex_funct3, ex_res, ex_rs2, ex_pc, ex_rd,
    output d_ack, d_data_in,
    input  stall, d_req, d_address, d_we, d_data_write,
    input  wb_valid, d_data_read, res, PC, opcode, rd, misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage. Issues loads/stores to data memory over
// a req/ack handshake, lane-aligns store data, extracts and extends load data
// and registers the result into the MEM/WB register.
//   clk   : pipeline clock
//   reset : asynchronous, active-high
//   bus   : mem_stage_if.master (EX inputs, stall, data-memory bus, MEM/WB outputs)
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.master  bus
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q;
  logic        wb_valid_q;
  logic [31:0] rdata_q, res_q, pc_q;
  logic [6:0]  opcode_q;
  logic [4:0]  rd_q;
  logic        mis_q;

  logic        is_load, is_store, is_mem, bad, req_new, d_req;
  logic [1:0]  a_lo;
  logic [31:0] rdata_d;
  logic [4:0]  rd_d;
  logic        mis_d;

  // Misaligned addresses and undefined funct3 encodings both make the access
  // unperformable; they are reported the same way.
  function automatic logic access_bad(input logic ld, input logic st,
                                      input logic [2:0] f3, input logic [1:0] a);
    logic b;
    b = 1'b0;
    if (ld) begin
      case (f3)
        3'b000, 3'b100: b = 1'b0;
        3'b001, 3'b101: b = a[0];
        3'b010:         b = (a != 2'b00);
        default:        b = 1'b1;
      endcase
    end else if (st) begin
      case (f3)
        3'b000:  b = 1'b0;
        3'b001:  b = a[0];
        3'b010:  b = (a != 2'b00);
        default: b = 1'b1;
      endcase
    end
    return b;
  endfunction

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    sh = w >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_we(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] we;
    case (f3)
      3'b000:  we = 4'b0001 << a;
      3'b001:  we = 4'b0011 << a;
      3'b010:  we = 4'b1111;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {4{d[7:0]}};
      3'b001:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode (combinational, from the held EX inputs)
  always_comb begin
    a_lo     = bus.ex_res[1:0];
    is_load  = (bus.ex_opcode == OPC_LOAD);
    is_store = (bus.ex_opcode == OPC_STORE);
    is_mem   = is_load | is_store;
    bad      = access_bad(is_load, is_store, bus.ex_funct3, a_lo);
    req_new  = bus.ex_valid & is_mem & ~bad;
  end

  // Reset gates the request immediately so an outstanding transaction is
  // abandoned in the same cycle, not at the next edge.
  assign d_req            = ~reset & ((state_q == WAIT) | ((state_q == IDLE) & req_new));
  assign bus.d_req        = d_req;
  assign bus.stall        = d_req;
  assign bus.d_address    = {bus.ex_res[31:2], 2'b00};
  assign bus.d_we         = (d_req & is_store) ? store_we(bus.ex_funct3, a_lo) : 4'b0000;
  assign bus.d_data_write = store_data(bus.ex_funct3, bus.ex_rs2);

  // MEM/WB next values
  always_comb begin
    mis_d   = is_mem & bad;
    rd_d    = mis_d ? 5'd0 : bus.ex_rd;
    rdata_d = (is_load & ~bad) ? load_align(bus.ex_funct3, a_lo, bus.d_data_in) : 32'd0;
  end

  // MEM/WB register and handshake state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      rdata_q    <= 32'd0;
      res_q      <= 32'd0;
      pc_q       <= 32'd0;
      opcode_q   <= 7'd0;
      rd_q       <= 5'd0;
      mis_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.ex_valid) begin
            wb_valid_q <= 1'b0;
          end else if (req_new && !bus.d_ack) begin
            wb_valid_q <= 1'b0;
            state_q    <= WAIT;
          end else begin
            wb_valid_q <= 1'b1;
            rdata_q    <= rdata_d;
            res_q      <= bus.ex_res;
            pc_q       <= bus.ex_pc;
            opcode_q   <= bus.ex_opcode;
            rd_q       <= rd_d;
            mis_q      <= mis_d;
          end
        end
        WAIT: begin
          if (bus.d_ack) begin
            wb_valid_q <= 1'b1;
            rdata_q    <= rdata_d;
            res_q      <= bus.ex_res;
            pc_q       <= bus.ex_pc;
            opcode_q   <= bus.ex_opcode;
            rd_q       <= rd_d;
            mis_q      <= mis_d;
            state_q    <= IDLE;
          end else begin
            // Nothing retires while the access is outstanding.
            wb_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wb_valid    = wb_valid_q;
  assign bus.d_data_read = rdata_q;
  assign bus.res         = res_q;
  assign bus.PC          = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.rd          = rd_q;
  assign bus.misaligned  = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with hand-computed expectations; expected
// MEM/WB contents are queued on issue and checked by an independent monitor.
module tb_mem_stage;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] JAL   = 7'b1101111;

  typedef struct {
    logic [31:0] data;
    logic [31:0] res;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] data, input logic [31:0] res,
                              input logic [31:0] pc, input logic [6:0] opc,
                              input logic [4:0] rd, input logic mis);
    exp_t e;
    e.data = data; e.res = res; e.pc = pc; e.opc = opc; e.rd = rd; e.mis = mis;
    return e;
  endfunction

  // Monitor: one retirement per cycle with wb_valid high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.wb_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got wb_valid=1 pc=%h expected no retirement", bus.PC);
        end else begin
          e = q.pop_front();
          chk("wb_data",   bus.d_data_read, e.data);
          chk("wb_res",    bus.res, e.res);
          chk("wb_pc",     bus.PC, e.pc);
          chk("wb_opcode", 32'(bus.opcode), 32'(e.opc));
          chk("wb_rd",     32'(bus.rd), 32'(e.rd));
          chk("wb_mis",    32'(bus.misaligned), 32'(e.mis));
        end
      end
    end
  end

  // Called just after a rising edge. Holds the instruction until ack_n cycles
  // after the request cycle (ack in cycle ack_n), then returns after that edge.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [31:0] pc, input logic [4:0] rd,
                        input int ack_n, input logic [31:0] rword, input exp_t e,
                        input int exp_stall, input logic [3:0] exp_we,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
    int stall_cnt;
    stall_cnt     = 0;
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = opc;
    bus.ex_funct3 = f3;
    bus.ex_res    = a;
    bus.ex_rs2    = rs2;
    bus.ex_pc     = pc;
    bus.ex_rd     = rd;
    bus.d_data_in = rword;
    q.push_back(e);
    for (int cyc = 0; cyc <= ack_n; cyc++) begin
      bus.d_ack = (cyc == ack_n);
      @(negedge clk);
      if (bus.stall === 1'b1) stall_cnt++;
      if (cyc == 0) begin
        chk("req", 32'(bus.d_req), (exp_stall > 0) ? 32'd1 : 32'd0);
        chk("we",  32'(bus.d_we), 32'(exp_we));
        if (exp_we != 4'b0000) chk("wdata", bus.d_data_write, exp_wdata);
      end
      if (exp_stall > 0) chk("addr", bus.d_address, exp_addr);
      @(posedge clk);
      #1;
    end
    bus.d_ack = 1'b0;
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
  endtask

  initial begin
    reset         = 1'b1;
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = LOAD;
    bus.ex_funct3 = 3'b010;
    bus.ex_res    = 32'h100;
    bus.ex_rs2    = 32'd0;
    bus.ex_pc     = 32'd0;
    bus.ex_rd     = 5'd0;
    bus.d_ack     = 1'b0;
    bus.d_data_in = 32'd0;
    #2;
    chk("rst_req",   32'(bus.d_req), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_we",    32'(bus.d_we), 32'd0);
    chk("rst_wbv",   32'(bus.wb_valid), 32'd0);
    chk("rst_data",  bus.d_data_read, 32'd0);
    chk("rst_res",   bus.res, 32'd0);
    chk("rst_pc",    bus.PC, 32'd0);
    chk("rst_opc",   32'(bus.opcode), 32'd0);
    chk("rst_rd",    32'(bus.rd), 32'd0);
    chk("rst_mis",   32'(bus.misaligned), 32'd0);
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.ex_valid = 1'b0;
    @(posedge clk); #1;

    // LW, ack two cycles after request
    run_op(LOAD, 3'b010, 32'h100, 32'd0, 32'h10, 5'd3, 2, 32'hDEADBEEF,
           mk(32'hDEADBEEF, 32'h100, 32'h10, LOAD, 5'd3, 1'b0), 3, 4'b0000, 32'd0, 32'h100);
    // LB / LBU / LH / LHU on word 0x80FF7F01
    run_op(LOAD, 3'b000, 32'h103, 32'd0, 32'h14, 5'd4, 0, 32'h80FF7F01,
           mk(32'hFFFFFF80, 32'h103, 32'h14, LOAD, 5'd4, 1'b0), 1, 4'b0000, 32'd0, 32'h100);
    run_op(LOAD, 3'b100, 32'h103, 32'd0, 32'h18, 5'd5, 1, 32'h80FF7F01,
           mk(32'h00000080, 32'h103, 32'h18, LOAD, 5'd5, 1'b0), 2, 4'b0000, 32'd0, 32'h100);
    run_op(LOAD, 3'b001, 32'h102, 32'd0, 32'h1C, 5'd6, 0, 32'h80FF7F01,
           mk(32'hFFFF80FF, 32'h102, 32'h1C, LOAD, 5'd6, 1'b0), 1, 4'b0000, 32'd0, 32'h100);
    run_op(LOAD, 3'b101, 32'h102, 32'd0, 32'h20, 5'd8, 3, 32'h80FF7F01,
           mk(32'h000080FF, 32'h102, 32'h20, LOAD, 5'd8, 1'b0), 4, 4'b0000, 32'd0, 32'h100);
    // SB zero-wait, SH one wait, SW aligned
    run_op(STORE, 3'b000, 32'h101, 32'h123456AB, 32'h24, 5'd9, 0, 32'hFFFFFFFF,
           mk(32'd0, 32'h101, 32'h24, STORE, 5'd9, 1'b0), 1, 4'b0010, 32'hABABABAB, 32'h100);
    run_op(STORE, 3'b001, 32'h102, 32'h0000BEEF, 32'h28, 5'd0, 1, 32'd0,
           mk(32'd0, 32'h102, 32'h28, STORE, 5'd0, 1'b0), 2, 4'b1100, 32'hBEEFBEEF, 32'h100);
    // Misaligned SW, then ADD
    run_op(STORE, 3'b010, 32'h102, 32'h11111111, 32'h2C, 5'd10, 0, 32'd0,
           mk(32'd0, 32'h102, 32'h2C, STORE, 5'd0, 1'b1), 0, 4'b0000, 32'd0, 32'd0);
    run_op(OP, 3'b000, 32'd5, 32'd0, 32'h30, 5'd7, 0, 32'd0,
           mk(32'd0, 32'd5, 32'h30, OP, 5'd7, 1'b0), 0, 4'b0000, 32'd0, 32'd0);
    // Illegal load funct3, misaligned LH
    run_op(LOAD, 3'b011, 32'h100, 32'd0, 32'h34, 5'd11, 0, 32'hFFFFFFFF,
           mk(32'd0, 32'h100, 32'h34, LOAD, 5'd0, 1'b1), 0, 4'b0000, 32'd0, 32'd0);
    run_op(LOAD, 3'b001, 32'h101, 32'd0, 32'h38, 5'd12, 0, 32'hFFFFFFFF,
           mk(32'd0, 32'h101, 32'h38, LOAD, 5'd0, 1'b1), 0, 4'b0000, 32'd0, 32'd0);
    run_op(STORE, 3'b010, 32'h104, 32'hCAFEF00D, 32'h3C, 5'd0, 0, 32'd0,
           mk(32'd0, 32'h104, 32'h3C, STORE, 5'd0, 1'b0), 1, 4'b1111, 32'hCAFEF00D, 32'h104);
    // JAL, then a bubble
    run_op(JAL, 3'b000, 32'h44, 32'd0, 32'h40, 5'd1, 0, 32'd0,
           mk(32'd0, 32'h44, 32'h40, JAL, 5'd1, 1'b0), 0, 4'b0000, 32'd0, 32'd0);
    bus.ex_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_wbv", 32'(bus.wb_valid), 32'd0);
    chk("bubble_pc",  bus.PC, 32'h40);
    chk("bubble_opc", 32'(bus.opcode), 32'(JAL));
    @(posedge clk); #1;

    // Reset while waiting for ack
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = LOAD;
    bus.ex_funct3 = 3'b010;
    bus.ex_res    = 32'h200;
    bus.ex_pc     = 32'h48;
    bus.ex_rd     = 5'd13;
    bus.d_ack     = 1'b0;
    @(negedge clk);
    chk("w_req0", 32'(bus.d_req), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w_req1", 32'(bus.d_req), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("wr_req",   32'(bus.d_req), 32'd0);
    chk("wr_stall", 32'(bus.stall), 32'd0);
    chk("wr_we",    32'(bus.d_we), 32'd0);
    chk("wr_wbv",   32'(bus.wb_valid), 32'd0);
    chk("wr_res",   bus.res, 32'd0);
    chk("wr_pc",    bus.PC, 32'd0);
    chk("wr_opc",   32'(bus.opcode), 32'd0);
    chk("wr_rd",    32'(bus.rd), 32'd0);
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.ex_valid = 1'b0;
    @(posedge clk); #1;
    run_op(OP, 3'b000, 32'd9, 32'd0, 32'h50, 5'd2, 0, 32'd0,
           mk(32'd0, 32'd9, 32'h50, OP, 5'd2, 1'b0), 0, 4'b0000, 32'd0, 32'd0);
    bus.ex_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline, between the execute stage and the write-back stage. It issues loads and stores to the data memory over a request/acknowledge handshake and aligns store data into byte lanes. It extracts and sign- or zero-extends load data, and registers the results into the MEM/WB pipeline register consumed by write-back. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
Parameters: none (fixed RV32I, 32-bit data path).

Ports (clock and reset first):
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_opcode  in  7  instruction opcode (LOAD, STORE, AUIPC, JAL, JALR, OP, ...).
- ex_funct3  in  3  access size/sign for LOAD/STORE.
- ex_res  in  32  ALU result; the effective address for LOAD/STORE.
- ex_rs2  in  32  store data.
- ex_pc  in  32  instruction PC.
- ex_rd  in  5  destination register index.
- stall  out  1  upstream must hold all ex_* inputs stable.
- d_req  out  1  data memory request.
- d_address  out  32  word address: {ex_res[31:2], 2'b00}.
- d_we  out  4  byte write enables; 0 for loads.
- d_data_write  out  32  lane-replicated store data.
- d_ack  in  1  memory completes the request; read data valid this cycle.
- d_data_in  in  32  raw read word.
- wb_valid  out  1  MEM/WB register holds a valid instruction.
- d_data_read  out  32  aligned, extended load result.
- res, PC  out  32 each  registered ex_res, ex_pc.
- opcode  out  7  registered ex_opcode.
- rd  out  5  registered ex_rd; forced to 0 on misaligned access.
- misaligned  out  1  registered flag for the instruction in MEM/WB.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, ex_valid=1, opcode LOAD/STORE, access aligned and funct3 legal: assert d_req combinationally, stall=1.
  - d_ack=1 in the same cycle: MEM/WB updates at the edge and the state stays IDLE.
  - Otherwise the state goes to WAIT.
- WAIT: d_req=1 and stall=1 with address, we and data held. On d_ack=1, MEM/WB captures the result at the edge, stall drops in that cycle, and the state returns to IDLE.
- Non-memory ops (ex_valid=1): no request, stall=0, MEM/WB captured at the next edge.
- ex_valid=0 in IDLE: wb_valid<=0 at the edge; other MEM/WB fields hold.
- Store byte enables: SB 4'b0001<<a[1:0]; SH 4'b0011<<a[1:0]; SW 4'b1111. Store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
- Load extraction uses the lane a[1:0]:
  - LB, LH: sign-extended.
  - LBU, LHU: zero-extended.
  - LW: the full word.
  - For stores and non-memory ops, d_data_read <= 0.
- Misaligned or illegal accesses:
  - Misaligned: halfword with a[0]=1; word with a[1:0]!=0.
  - Illegal funct3: LOAD 011/110/111; STORE other than 000/001/010.
  - Response: no d_req, stall=0, single-cycle pass to MEM/WB with misaligned=1, rd=0, wb_valid=1.
- d_ack while d_req=0 is ignored.

## Timing
- Reset values: state IDLE; wb_valid, misaligned, d_data_read, res, PC, opcode, rd all 0. d_req, d_we and stall are 0 while reset is high.
- Non-memory op and zero-wait memory op: 1-cycle latency, ex inputs to MEM/WB.
- Memory op with N-cycle ack (N>=1 after request cycle): N+1 cycles, stall high for N+1 cycles.
- d_req remains high continuously from the request cycle through the ack cycle. The request fields do not change while d_req=1.
- Reset asserted in WAIT: d_req drops immediately (asynchronous) and the memory discards the transaction. The state returns to IDLE.
- Back-to-back memory ops: a second request may issue in the cycle after an ack.

## Test plan
- Reset in WAIT: LW issued, reset asserted before ack -> d_req=0 in the same cycle, all outputs 0, then IDLE.
- LW a=0x100, d_data_in=0xDEADBEEF, ack after 2 cycles -> stall high 3 cycles; then d_data_read=0xDEADBEEF, wb_valid=1, rd kept.
- LB a=0x103 and LBU a=0x103, word 0x80FF7F01 -> 0xFFFFFF80 and 0x00000080; LH a=0x102 -> 0xFFFF80FF.
- SB a=0x101, rs2=0x123456AB, zero-wait ack -> d_we=4'b0010, d_data_write=0xABABABAB, d_address=0x100, stall one cycle.
- SW a=0x102 -> no d_req, misaligned=1, rd=0, stall=0. Next op, ADD res=5 rd=7 -> wb_valid=1, res=5, rd=7, misaligned=0.
- JAL pc=0x40 followed by ex_valid=0 -> PC=0x40 and opcode=JAL registered, then wb_valid=0.
